// File: rtl/mul_recon_pkg.sv
// Shared widths, FSM encoding and transistor counts for the quotient/divisor/remainder
// reconstructor and its cells.
package mul_recon_pkg;

  localparam int BW_Q  = 8;
  localparam int BW_B  = 5;
  localparam int BW_A  = BW_Q + BW_B;
  localparam int NUM_W = 51;

  typedef logic [NUM_W-1:0] tcount_t;
  typedef logic [1:0]       state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Per-cell transistor counts of the gate-level library.
  localparam tcount_t T_INV   = 51'd2;
  localparam tcount_t T_NAND2 = 51'd4;
  localparam tcount_t T_NOR2  = 51'd4;
  localparam tcount_t T_AND2  = 51'd6;
  localparam tcount_t T_XOR2  = 51'd12;
  localparam tcount_t T_HA    = 51'd14;
  localparam tcount_t T_FA    = 51'd28;
  localparam tcount_t T_MUXP  = 51'd12;
  localparam tcount_t T_FD2   = 51'd26;

  // Register bits: state 2, acc 13, mcand 13, mplier 5, cnt 3, result 13, valid 1.
  localparam int N_REG_BITS = 2 + BW_A + BW_A + BW_B + 3 + BW_A + 1;
  localparam int N_MUX_BITS = BW_A;

  // Counter incrementer, terminal-count compare and state decode.
  localparam tcount_t T_FSM = 3 * T_XOR2 + 2 * T_AND2 + 4 * T_NOR2 + 3 * T_INV + 2 * T_NAND2;

  typedef struct packed {
    logic [BW_Q-1:0] q;
    logic [BW_B-1:0] b;
    logic [BW_B-1:0] r;
  } req_t;

  function automatic logic [BW_A-1:0] zext_q(input logic [BW_Q-1:0] q);
    return {{(BW_A - BW_Q){1'b0}}, q};
  endfunction

  function automatic logic [BW_A-1:0] zext_b(input logic [BW_B-1:0] v);
    return {{(BW_A - BW_B){1'b0}}, v};
  endfunction

endpackage

// File: rtl/mul_recon_add13.sv
// 13-bit ripple-carry adder from library half/full-adder cells; each cell
// reports its transistor count and the adder sums them.
module mul_recon_ha
  import mul_recon_pkg::*;
(
  input  logic              i_a,
  input  logic              i_b,
  output logic              o_s,
  output logic              o_c,
  output logic [NUM_W-1:0]  number
);
  assign o_s    = i_a ^ i_b;
  assign o_c    = i_a & i_b;
  assign number = T_HA;
endmodule

module mul_recon_fa
  import mul_recon_pkg::*;
(
  input  logic              i_a,
  input  logic              i_b,
  input  logic              i_c,
  output logic              o_s,
  output logic              o_c,
  output logic [NUM_W-1:0]  number
);
  assign o_s    = i_a ^ i_b ^ i_c;
  assign o_c    = (i_a & i_b) | (i_c & (i_a ^ i_b));
  assign number = T_FA;
endmodule

module add13
  import mul_recon_pkg::*;
(
  input  logic [12:0]       i_a,
  input  logic [12:0]       i_b,
  output logic [12:0]       o_s,
  output logic [NUM_W-1:0]  number
);
  logic [11:0]      w_c;
  logic             w_unused_c12;
  logic [NUM_W-1:0] w_cell_num [13];

  mul_recon_ha u_ha0 (
    .i_a    (i_a[0]),
    .i_b    (i_b[0]),
    .o_s    (o_s[0]),
    .o_c    (w_c[0]),
    .number (w_cell_num[0])
  );

  genvar g;
  generate
    for (g = 1; g < 12; g++) begin : g_fa
      mul_recon_fa u_fa (
        .i_a    (i_a[g]),
        .i_b    (i_b[g]),
        .i_c    (w_c[g-1]),
        .o_s    (o_s[g]),
        .o_c    (w_c[g]),
        .number (w_cell_num[g])
      );
    end
  endgenerate

  // The result never exceeds 13 bits, so the final carry is dropped.
  mul_recon_fa u_fa12 (
    .i_a    (i_a[12]),
    .i_b    (i_b[12]),
    .i_c    (w_c[11]),
    .o_s    (o_s[12]),
    .o_c    (w_unused_c12),
    .number (w_cell_num[12])
  );

  always_comb begin
    number = '0;
    for (int i = 0; i < 13; i++) begin
      number = number + w_cell_num[i];
    end
  end
endmodule

// File: rtl/mul_recon.sv
// Sequential shift-add reconstructor: a = q*b + r over five iterations, the
// round-trip partner of the 8-bit/5-bit divider.
// Handshake: a request is taken on a rising edge where o_ready=1 and i_in_valid=1;
// the result is presented with o_out_valid=1 for exactly one cycle, no backpressure.
module mul_recon #(
  parameter int BW_Q = mul_recon_pkg::BW_Q,
  parameter int BW_B = mul_recon_pkg::BW_B,
  parameter int BW_A = BW_Q + BW_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  input  logic [BW_Q-1:0]   i_q,
  input  logic [BW_B-1:0]   i_b,
  input  logic [BW_B-1:0]   i_r,
  output logic              o_ready,
  output logic [BW_A-1:0]   o_a,
  output logic              o_out_valid,
  output logic [50:0]       number
);
  import mul_recon_pkg::*;

  logic [1:0]       r_state;
  logic [BW_A-1:0]  r_acc;
  logic [BW_A-1:0]  r_mcand;
  logic [BW_B-1:0]  r_mplier;
  logic [2:0]       r_cnt;
  logic [BW_A-1:0]  r_a;
  logic             r_out_valid;

  logic [1:0]       w_state_nxt;
  logic [BW_A-1:0]  w_acc_nxt;
  logic [BW_A-1:0]  w_mcand_nxt;
  logic [BW_B-1:0]  w_mplier_nxt;
  logic [2:0]       w_cnt_nxt;
  logic [BW_A-1:0]  w_a_nxt;
  logic             w_out_valid_nxt;

  logic [BW_A-1:0]  w_sum;
  logic [BW_A-1:0]  w_add_sel;
  logic [50:0]      w_add_num;
  logic             w_last;

  add13 u_add13 (
    .i_a    (r_acc),
    .i_b    (r_mcand),
    .o_s    (w_sum),
    .number (w_add_num)
  );

  // Per-bit MUXP: keep the accumulator or take the partial sum.
  genvar g;
  generate
    for (g = 0; g < BW_A; g++) begin : g_mux
      assign w_add_sel[g] = r_mplier[0] ? w_sum[g] : r_acc[g];
    end
  endgenerate

  assign w_last = (r_cnt == 3'(BW_B - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_mcand_nxt     = r_mcand;
    w_mplier_nxt    = r_mplier;
    w_cnt_nxt       = r_cnt;
    w_a_nxt         = r_a;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_acc_nxt    = zext_b(i_r);
          w_mcand_nxt  = zext_q(i_q);
          w_mplier_nxt = i_b;
          w_cnt_nxt    = 3'd0;
          w_state_nxt  = S_CALC;
        end
      end
      S_CALC: begin
        w_acc_nxt    = w_add_sel;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + 3'd1;
        if (w_last) begin
          w_a_nxt         = w_add_sel;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FD2 banks; reset clears every register including the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_cnt       <= w_cnt_nxt;
      r_a         <= w_a_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_a         = r_a;
  assign o_out_valid = r_out_valid;

  assign number = w_add_num
                + tcount_t'(N_MUX_BITS) * T_MUXP
                + tcount_t'(N_REG_BITS) * T_FD2
                + T_FSM;
endmodule
